// File: rtl/cim_pkg.sv
// Shared definitions for the CIM add-round-key / S-box controller.
//   phase_e      : controller phase, encoding visible on the PHASE port
//   NumRoundKeys : default size of the round-key store (NRK)
//   RndLast      : last round index; RND saturates here
package cim_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArk  = 2'd1,
    StTurn = 2'd2,
    StLut  = 2'd3
  } phase_e;

  localparam int unsigned NumRoundKeys = 11;
  localparam logic [3:0]  RndLast      = 4'd10;

endpackage

// File: rtl/aes_sbox_rom.sv
// Combinational FIPS-197 forward S-box, 256 x 8.
//   addr : byte to substitute
//   data : S-box output for addr
module aes_sbox_rom (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [2047:0] table_sh;

  assign table_sh = SboxTable << {addr, 3'b000};
  assign data     = table_sh[2047:2040];

endmodule

// File: rtl/cim_ark_sbox_ctrl.sv
// Round controller for a bit-serial AES core backed by a compute-in-memory S-box.
// Each round: 8 ARK cycles (one key bit-plane XORed per cycle), one TURN cycle,
// one LUT cycle registering 16 S-box lookups.
//   CLK, RST        : clock, synchronous active-high reset
//   KWR/KIDX/KDATA  : round-key store write port
//   KDRDY           : new-block start, restarts at round 0
//   BSY             : core busy; enables / aborts rounds
//   IN              : bit-serial state bits from the core
//   LUT_ADDR        : 16 S-box addresses, byte j at [8j+7:8j]
//   RIO             : 16 result bytes, byte j at [8j+7:8j]
//   PHASE/RND/DONE  : phase, round index, end-of-block pulse
module cim_ark_sbox_ctrl
  import cim_pkg::*;
#(
  parameter int unsigned NRK = NumRoundKeys
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         KWR,
  input  logic [3:0]   KIDX,
  input  logic [127:0] KDATA,
  input  logic         KDRDY,
  input  logic         BSY,
  input  logic [15:0]  IN,
  input  logic [127:0] LUT_ADDR,
  output logic [127:0] RIO,
  output logic [1:0]   PHASE,
  output logic [3:0]   RND,
  output logic         DONE
);

  phase_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] rio_q, rio_d;
  logic         done_q, done_d;

  logic [127:0] key_q [NRK];
  logic [127:0] key_cur, key_sh, ark_rio, sbox_out;
  logic [15:0]  in_sh;
  logic [7:0]   ark_lo, ark_hi;

  // Key store is deliberately outside reset so keys survive RST.
  always_ff @(posedge CLK) begin
    if (KWR && ({28'd0, KIDX} < NRK)) begin
      key_q[KIDX] <= KDATA;
    end
  end

  always_comb begin
    key_cur = '0;
    if ({28'd0, rnd_q} < NRK) begin
      key_cur = key_q[rnd_q];
    end
  end

  // Shifting by CNT brings bit 7-CNT of every key byte to that byte's MSB position,
  // and IN[CNT]/IN[CNT+8] down to bits 0/8, so the selects below are constant.
  assign key_sh = key_cur << cnt_q;
  assign in_sh  = IN >> cnt_q;

  for (genvar i = 0; i < 8; i++) begin : g_ark_bit
    // Lowest key byte index lands in the result MSB.
    assign ark_lo[7-i] = key_sh[127-16*i] ^ in_sh[8];
    assign ark_hi[7-i] = key_sh[119-16*i] ^ in_sh[0];
  end

  for (genvar j = 0; j < 8; j++) begin : g_ark_byte
    assign ark_rio[8*j +: 8]      = (cnt_q == 3'(j)) ? ark_lo : rio_q[8*j +: 8];
    assign ark_rio[8*j+64 +: 8]   = (cnt_q == 3'(j)) ? ark_hi : rio_q[8*j+64 +: 8];
  end

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox_rom u_sbox (
      .addr (LUT_ADDR[8*g +: 8]),
      .data (sbox_out[8*g +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    rio_d   = rio_q;
    done_d  = 1'b0;
    if (KDRDY) begin
      state_d = StIdle;
      rnd_d   = 4'd0;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (BSY) begin
            state_d = StArk;
            cnt_d   = 3'd0;
          end
        end
        StArk: begin
          if (!BSY) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
          end else begin
            rio_d = ark_rio;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = StTurn;
            end
          end
        end
        StTurn: begin
          state_d = BSY ? StLut : StIdle;
          cnt_d   = 3'd0;
        end
        StLut: begin
          rio_d   = sbox_out;
          rnd_d   = (rnd_q >= RndLast) ? RndLast : rnd_q + 4'd1;
          done_d  = (rnd_q == RndLast);
          state_d = BSY ? StArk : StIdle;
          cnt_d   = 3'd0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      rnd_q   <= 4'd0;
      rio_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      rio_q   <= rio_d;
      done_q  <= done_d;
    end
  end

  assign RIO   = rio_q;
  assign PHASE = state_q;
  assign RND   = rnd_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_cim_ark_sbox_ctrl.sv
// Directed bench for cim_ark_sbox_ctrl: ARK bit-plane loads, S-box lookups,
// full 11-round run, abort, KDRDY restart, reset with key retention.
module tb_cim_ark_sbox_ctrl;

  logic         CLK;
  logic         RST;
  logic         KWR;
  logic [3:0]   KIDX;
  logic [127:0] KDATA;
  logic         KDRDY;
  logic         BSY;
  logic [15:0]  IN;
  logic [127:0] LUT_ADDR;
  logic [127:0] RIO;
  logic [1:0]   PHASE;
  logic [3:0]   RND;
  logic         DONE;

  int checks = 0;
  int errors = 0;

  cim_ark_sbox_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .KWR      (KWR),
    .KIDX     (KIDX),
    .KDATA    (KDATA),
    .KDRDY    (KDRDY),
    .BSY      (BSY),
    .IN       (IN),
    .LUT_ADDR (LUT_ADDR),
    .RIO      (RIO),
    .PHASE    (PHASE),
    .RND      (RND),
    .DONE     (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  localparam logic [127:0] Key0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Key1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  logic [1:0] exp_ph;

  initial begin
    RST = 1'b1; KWR = 1'b0; KIDX = '0; KDATA = '0; KDRDY = 1'b0;
    BSY = 1'b0; IN = '0; LUT_ADDR = '0;
    tick(); tick();
    chk("rst_phase", {126'd0, PHASE}, 128'd0);
    chk("rst_rnd", {124'd0, RND}, 128'd0);
    chk("rst_rio", RIO, 128'd0);
    chk("rst_done", {127'd0, DONE}, 128'd0);
    RST = 1'b0;

    // Keys 2..10 are a repeated byte equal to the index.
    for (int i = 0; i < 11; i++) begin
      KWR = 1'b1; KIDX = 4'(i);
      KDATA = (i == 0) ? Key0 : (i == 1) ? Key1 : {16{8'(i)}};
      tick();
    end
    KWR = 1'b0;
    chk("idle_after_keys", {126'd0, PHASE}, 128'd0);

    // Round 0 with key 0
    BSY = 1'b1; tick();
    chk("ark_enter", {126'd0, PHASE}, 128'd1);
    IN = 16'h0000; tick();
    chk("r0_k0_byte0", {120'd0, RIO[7:0]}, 128'h18);
    chk("r0_k0_byte8", {120'd0, RIO[71:64]}, 128'h3e);
    IN = 16'h0200; tick();
    chk("r0_k1_byte1", {120'd0, RIO[15:8]}, 128'hee);
    chk("r0_k1_byte9", {120'd0, RIO[79:72]}, 128'h8a);
    IN = 16'h0000;
    repeat (6) tick();
    chk("turn_phase", {126'd0, PHASE}, 128'd2);
    LUT_ADDR = 128'hff000000_00000000_00000000_00005300;
    tick();
    chk("lut_phase", {126'd0, PHASE}, 128'd3);
    chk("turn_holds", {120'd0, RIO[7:0]}, 128'h18);
    tick();
    chk("sbox_rio", RIO, 128'h16636363_63636363_63636363_6363ed63);
    chk("lut_rnd", {124'd0, RND}, 128'd1);
    chk("lut_to_ark", {126'd0, PHASE}, 128'd1);

    // Round 1 with key 1
    tick();
    chk("r1_in0_byte0", {120'd0, RIO[7:0]}, 128'haa);
    chk("r1_in0_byte8", {120'd0, RIO[71:64]}, 128'hff);
    BSY = 1'b0; tick();
    chk("abort_phase", {126'd0, PHASE}, 128'd0);
    chk("abort_rnd", {124'd0, RND}, 128'd1);
    chk("abort_no_load", {120'd0, RIO[15:8]}, 128'hed);
    BSY = 1'b1; tick();
    chk("resume_ark", {126'd0, PHASE}, 128'd1);
    IN = 16'hffff; tick();
    chk("r1_inf_byte0", {120'd0, RIO[7:0]}, 128'h55);
    chk("r1_inf_byte8", {120'd0, RIO[71:64]}, 128'h00);
    IN = 16'h0000;
    repeat (3) tick();
    chk("r1_k1_byte1", {120'd0, RIO[15:8]}, 128'hff);
    BSY = 1'b0; tick();
    chk("k4_abort_phase", {126'd0, PHASE}, 128'd0);
    chk("k4_abort_rnd", {124'd0, RND}, 128'd1);
    chk("k4_abort_hi", {96'd0, RIO[127:96]}, 128'h16636363);
    chk("k4_abort_lo", {96'd0, RIO[63:32]}, 128'h63636363);

    KDRDY = 1'b1; tick(); KDRDY = 1'b0;
    chk("kdrdy_phase", {126'd0, PHASE}, 128'd0);
    chk("kdrdy_rnd", {124'd0, RND}, 128'd0);

    // Full block with BSY held high
    BSY = 1'b1; tick();
    for (int r = 0; r <= 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        exp_ph = (c < 8) ? 2'd1 : (c == 8) ? 2'd2 : 2'd3;
        chk("run_phase", {126'd0, PHASE}, {126'd0, exp_ph});
        chk("run_rnd", {124'd0, RND}, 128'(r));
        chk("run_done", {127'd0, DONE}, 128'd0);
        tick();
      end
    end
    chk("done_pulse", {127'd0, DONE}, 128'd1);
    chk("rnd_saturate", {124'd0, RND}, 128'd10);
    chk("post_run_ark", {126'd0, PHASE}, 128'd1);
    BSY = 1'b0; tick();
    chk("done_one_cycle", {127'd0, DONE}, 128'd0);
    chk("post_run_idle", {126'd0, PHASE}, 128'd0);

    // KDRDY during LUT of round 6
    KDRDY = 1'b1; tick(); KDRDY = 1'b0;
    BSY = 1'b1; tick();
    repeat (69) tick();
    chk("r6_lut_phase", {126'd0, PHASE}, 128'd3);
    chk("r6_lut_rnd", {124'd0, RND}, 128'd6);
    chk("r6_ark_rio", RIO, 128'h00ffff00_00000000_00ffff00_00000000);
    LUT_ADDR = {16{8'h53}};
    KDRDY = 1'b1; BSY = 1'b0; tick(); KDRDY = 1'b0;
    chk("kdrdy_lut_phase", {126'd0, PHASE}, 128'd0);
    chk("kdrdy_lut_rnd", {124'd0, RND}, 128'd0);
    chk("kdrdy_lut_rio", RIO, 128'h00ffff00_00000000_00ffff00_00000000);

    // Out-of-range key writes, then reset mid-ARK
    KWR = 1'b1; KDATA = {128{1'b1}};
    KIDX = 4'd11; tick();
    KIDX = 4'd15; tick();
    KWR = 1'b0;
    BSY = 1'b1; tick();
    IN = 16'h0000; tick();
    chk("key0_kept", {120'd0, RIO[7:0]}, 128'h18);
    tick(); tick();
    RST = 1'b1; tick();
    chk("rst2_rio", RIO, 128'd0);
    chk("rst2_phase", {126'd0, PHASE}, 128'd0);
    chk("rst2_rnd", {124'd0, RND}, 128'd0);
    chk("rst2_done", {127'd0, DONE}, 128'd0);
    RST = 1'b0; tick();
    chk("rst2_ark", {126'd0, PHASE}, 128'd1);
    tick();
    chk("rst2_key_rio", RIO, 128'h00000000_0000003e_00000000_00000018);
    BSY = 1'b0; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cim_ark_sbox_ctrl.md
CIM_ARK_SBOX_CTRL -- requirements
Module: cim_ark_sbox_ctrl

Interface
REQ-001 The block SHALL have a parameter NRK, default 11, giving the number of stored round keys.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port KWR, input, 1 bit: round-key write strobe.
REQ-005 The block SHALL have port KIDX, input, 4 bits: round-key write index.
REQ-006 The block SHALL have port KDATA, input, 128 bits: round-key value; byte b is KDATA[127-8b -: 8].
REQ-007 The block SHALL have port KDRDY, input, 1 bit: new-block start pulse from the AES core.
REQ-008 The block SHALL have port BSY, input, 1 bit: AES core busy.
REQ-009 The block SHALL have port IN, input, 16 bits: bit-serial state bits from the AES core.
REQ-010 The block SHALL have port LUT_ADDR, input, 128 bits: 16 S-box addresses; byte j is [8j+7:8j] = {DEMUX_ADD_j[1:0], RWL_DEC_ADD_j[5:0]}.
REQ-011 The block SHALL have port RIO, output, 128 bits: 16 result bytes to the core; byte j is [8j+7:8j].
REQ-012 The block SHALL have port PHASE, output, 2 bits: current state (IDLE=0, ARK=1, TURN=2, LUT=3).
REQ-013 The block SHALL have port RND, output, 4 bits: current round index, 0..10.
REQ-014 The block SHALL have port DONE, output, 1 bit: one-cycle pulse marking end of block.

Function
REQ-015 The key store SHALL be NRK x 128 registers; KWR=1 with KIDX<NRK writes KDATA at the edge; KIDX>=NRK is ignored; a same-cycle read returns the old value.
REQ-016 The FSM SHALL have states IDLE, ARK, TURN and LUT; a bit counter CNT (0..7) is meaningful only in ARK.
REQ-017 In IDLE, BSY=1 SHALL move the FSM to ARK with CNT=0; otherwise RIO holds.
REQ-018 In ARK with CNT=k, RIO byte k SHALL load {bit 7-k of key[RND] bytes 0,2,4,...,14} XOR {8{IN[k+8]}}.
REQ-019 In ARK with CNT=k, RIO byte k+8 SHALL load {bit 7-k of key[RND] bytes 1,3,...,15} XOR {8{IN[k]}}; MSB of each result comes from the lowest byte index.
REQ-020 In ARK, RIO bytes other than k and k+8 SHALL hold; CNT increments, and after k=7 the FSM moves to TURN.
REQ-021 TURN SHALL last exactly one cycle with RIO held, then move to LUT.
REQ-022 In LUT, every RIO byte j SHALL load SBOX[LUT_ADDR byte j] (FIPS-197 forward S-box), so data is visible one cycle after the address is presented.
REQ-023 In LUT, RND SHALL become min(RND+1, 10); the next state is ARK (CNT=0) if BSY=1, else IDLE.
REQ-024 DONE SHALL pulse for exactly one cycle, the cycle after a LUT cycle that began with RND=10.
REQ-025 BSY falling in ARK or TURN SHALL abort to IDLE, clear CNT, and hold RND and RIO.
REQ-026 KDRDY=1 in any state SHALL force IDLE, RND=0 and CNT=0, with RIO held; KDRDY has priority over BSY and over state transitions, and RST has priority over KDRDY.
REQ-027 One full round SHALL take 10 cycles (8 ARK + TURN + LUT).

Reset
REQ-028 RST=1 at an edge SHALL set PHASE=IDLE, CNT=0, RND=0, RIO=0 and DONE=0.
REQ-029 RST SHALL leave the key store unchanged, and SHALL abort any in-flight round.

Structure
REQ-030 A shared package cim_pkg SHALL hold the phase enum, NRK and the round-limit constant 10.
REQ-031 One sub-module, aes_sbox_rom (combinational 256x8 forward S-box), SHALL be instantiated 16 times; LUT registers its outputs.

Verification
REQ-032 Load key[1]=d6aa74fdd2af72fadaa678f1d6ab76fe, force RND=1, IN=0000 at k=0 -> RIO byte0=AA; with IN=FFFF -> byte0=55.
REQ-033 LUT_ADDR byte0=00, byte1=53, byte15=FF in LUT -> RIO byte0=63, byte1=ED, byte15=16 next cycle.
REQ-034 BSY held high from reset -> PHASE sequence ARKx8, TURN, LUT repeats; RND 0..10 saturates; DONE pulses once, about 110 cycles in.
REQ-035 BSY dropped at k=4 -> IDLE next cycle; RND unchanged; RIO bytes 5..7 and 13..15 unchanged.
REQ-036 KDRDY pulse mid-LUT with RND=6 -> next cycle PHASE=IDLE and RND=0, with no S-box load.
REQ-037 KWR with KIDX=11 -> store unchanged; RST mid-ARK -> all outputs zero and keys retained.
